// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state encoding and counter sizing for the button event generator
package button_event_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    // Bits needed to hold any value 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// rtl/button_event_channel.sv - per-button edge detect, IDLE/PRESSED/HELD FSM and strobe registers
// Auto-repeat logic is present only when BUTTON_AUTOREPEAT_EN is defined.
module button_event_channel
    import button_event_pkg::*;
#(
    parameter int LONG_TICKS   = 1000
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_TICKS = 200
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic tick,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int HW = cnt_width(LONG_TICKS);

    logic          prev;
    logic          rise_q;
    logic          fall_q;
    logic          tick_q;
    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;

    assign held = (state == ST_HELD);

    // Edges and tick are staged together so a tick coinciding with the press edge stays uncounted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev          <= din;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            tick_q        <= 1'b0;
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            prev          <= din;
            rise_q        <= din & ~prev;
            fall_q        <= ~din & prev;
            tick_q        <= tick;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise_q) begin
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (fall_q) begin
                        release_pulse <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (tick_q) begin
                        if (hold_cnt == HW'(LONG_TICKS - 1)) begin
                            long_pulse <= 1'b1;
                            state      <= ST_HELD;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (fall_q) begin
                        release_pulse <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_TICKS);

    logic [RW-1:0] rep_cnt;

    // rep_cnt is held at zero outside HELD, so it starts fresh at every long_pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (state != ST_HELD) begin
                rep_cnt <= '0;
            end else if (tick_q && !fall_q) begin
                if (rep_cnt == RW'(REPEAT_TICKS - 1)) begin
                    repeat_pulse <= 1'b1;
                    rep_cnt      <= '0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - shared tick prescaler plus one event channel per debounced button
// Define BUTTON_AUTOREPEAT_EN to enable repeat_pulse; otherwise it is tied to 0.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int TICK_CYCLES  = 125000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_in,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    localparam int CW = cnt_width(TICK_CYCLES - 1);

    logic [CW-1:0] count;
    logic          tick;

    // Unsupported parameter values open this empty scope so they are visible in the elaborated hierarchy.
    if (TICK_CYCLES < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_invalid_config
    end

    assign tick = (count == CW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_event_channel #(
            .LONG_TICKS   (LONG_TICKS)
`ifdef BUTTON_AUTOREPEAT_EN
            ,
            .REPEAT_TICKS (REPEAT_TICKS)
`endif
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .din           (debounced_in[i]),
            .tick          (tick),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .held          (held[i])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - per-cycle vector table plus latency/window sequences for button_event_gen
module tb_button_event_gen;

    localparam int WIDTH = 4;
    localparam int TC    = 4;
    localparam int LT    = 3;
    localparam int RT    = 2;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] debounced_in = '0;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_pulse;
    logic [WIDTH-1:0] repeat_pulse;
    logic [WIDTH-1:0] held;

    always #5 clk = ~clk;

    button_event_gen #(
        .WIDTH        (WIDTH),
        .TICK_CYCLES  (TC),
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .debounced_in  (debounced_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    typedef struct {
        logic       rst;
        logic [3:0] din;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] rep;
        logic [3:0] held;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input int n, input logic r, input logic [3:0] d, input logic [3:0] p,
                       input logic [3:0] rl, input logic [3:0] l, input logic [3:0] rp,
                       input logic [3:0] h);
        vec_t v;
        v.rst   = r;
        v.din   = d;
        v.press = p;
        v.rel   = rl;
        v.lng   = l;
        v.rep   = rp & {4{AR}};
        v.held  = h;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check4(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int dly;

        rst          = 1'b1;
        debounced_in = 4'b0001;
        repeat (2) @(posedge clk);

        // Timebase ticks land in cycles 5, 9, 13, ... (count restarts at 0 in cycle 2).
        //  n  rst  din      press    rel      long     rep      held
        add(2, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(2, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(2, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1101, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1101, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(3, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(1, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(2, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 1'b0, 4'b1001, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0001);
        add(3, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b1001);
        add(7, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        add(1, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b1001);
        add(7, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        add(1, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b1001);
        add(2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        add(1, 1'b0, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(2, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(2, 1'b1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(3, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst          = vecs[i].rst;
            debounced_in = vecs[i].din;
            @(negedge clk);
            check4("press_pulse",   i, press_pulse,   vecs[i].press);
            check4("release_pulse", i, release_pulse, vecs[i].rel);
            check4("long_pulse",    i, long_pulse,    vecs[i].lng);
            check4("repeat_pulse",  i, repeat_pulse,  vecs[i].rep);
            check4("held",          i, held,          vecs[i].held);
        end

        // Press-to-strobe latency, strobe width and press-to-long window on a free-running timebase.
        @(posedge clk);
        #1;
        debounced_in = 4'b0010;
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (press_pulse[1]) lat = k;
        end
        check_range("press_latency", lat, 2, 2);
        @(negedge clk);
        check4("press_width", 0, press_pulse, 4'b0000);
        dly = 1;
        while (dly < 30 && !long_pulse[1]) begin
            @(negedge clk);
            dly++;
        end
        check_range("press_to_long", dly, (LT - 1) * TC, LT * TC);
        check4("held_at_long", 0, held, 4'b0010);
        @(negedge clk);
        check4("long_width", 0, long_pulse, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
